spi_xfer_arbiter: RTL

//  Shares one SPI transfer engine between NUM_REQ requesters (Avalon slaves / DMA).

---
 rtl/spi_xfer_arbiter_if.sv | 27 ++
 rtl/spi_xfer_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if: requester/engine-side bundle shared with the SPI transfer arbiter
interface spi_xfer_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic                      xfer_err;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      go_transfer;
    logic [DATA_W-1:0]         data_write_to_spi;
    logic                      data_pack_ready;
    logic [DATA_W-1:0]         data_read_from_spi;

    modport master (
        output req, req_wdata, data_pack_ready, data_read_from_spi,
        input  grant, done, xfer_err, rdata, busy, go_transfer, data_write_to_spi
    );

    modport slave (
        input  req, req_wdata, data_pack_ready, data_read_from_spi,
        output grant, done, xfer_err, rdata, busy, go_transfer, data_write_to_spi
    );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI engine with go pulse, ready sync and watchdog
module spi_xfer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int GO_LEN  = 7,
    parameter int TMO_CYC = 4096
) (
    input logic            clk,
    input logic            reset_n,
    spi_xfer_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int GW = (GO_LEN > 1) ? $clog2(GO_LEN) : 1;
    localparam int TW = $clog2(TMO_CYC);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, COMPLETE} state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      rr_ptr, sel, idx;
    logic               found;
    logic [GW-1:0]      go_cnt;
    logic [TW-1:0]      tmo;
    logic               s1, s2, s3;
    logic               rdy_edge, tmo_hit;
    logic [NUM_REQ-1:0] grant;
    logic               go;
    logic               err;
    logic [DATA_W-1:0]  wdata_q, rdata_q;
    logic [DATA_W-1:0]  words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    assign rdy_edge              = s2 & ~s3;
    assign tmo_hit               = tmo == TW'(TMO_CYC - 1);
    assign bus.grant             = grant;
    assign bus.done              = (state == COMPLETE) ? grant : '0;
    assign bus.xfer_err          = err;
    assign bus.rdata             = rdata_q;
    assign bus.busy              = state != IDLE;
    assign bus.go_transfer       = go;
    assign bus.data_write_to_spi = wdata_q;

    // bring the engine's ready level into clk domain, with one extra stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {s1, s2, s3} <= '0;
        else          {s1, s2, s3} <= {bus.data_pack_ready, s1, s2};
    end

    // first requester at or after rr_ptr, wrapping around
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next state; a ready edge beats a same-cycle timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = found ? LAUNCH : IDLE;
            LAUNCH:    state_nxt = (go_cnt == '0) ? WAIT_DONE : LAUNCH;
            WAIT_DONE: state_nxt = (rdy_edge || tmo_hit) ? COMPLETE : WAIT_DONE;
            default:   state_nxt = IDLE;
        endcase
    end

    // grant, go pulse, watchdog counter and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant   <= '0;
            go      <= 1'b0;
            go_cnt  <= '0;
            tmo     <= '0;
            err     <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant   <= NUM_REQ'(1) << sel;
                    wdata_q <= words[sel];
                    go      <= 1'b1;
                    go_cnt  <= GW'(GO_LEN - 1);
                    tmo     <= '0;
                    rr_ptr  <= (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                end
                LAUNCH: begin
                    if (go_cnt == '0) go <= 1'b0;
                    else              go_cnt <= go_cnt - 1'b1;
                end
                WAIT_DONE: begin
                    if (rdy_edge) begin
                        rdata_q <= bus.data_read_from_spi;
                        err     <= 1'b0;
                    end else if (tmo_hit) begin
                        err <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: grant <= '0;
            endcase
        end
    end
endmodule
